// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day engine and its display mapping.
package clock_pkg;

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_e;

  localparam logic [3:0] DIG_DASH  = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hB;

  localparam logic [7:0] MASK_HOUR = 8'b1100_0000;
  localparam logic [7:0] MASK_MIN  = 8'b0001_1000;
  localparam logic [7:0] MASK_SEC  = 8'b0000_0011;

  // Packs a small binary value (0..99) as {tens, ones} BCD.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter with programmable modulus; reset loads a BCD value.
module bcd_mod_counter #(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] load_val,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry
);

  localparam logic [3:0] MAX_T = 4'((MOD - 1) / 10);
  localparam logic [3:0] MAX_O = 4'((MOD - 1) % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_max;

  assign at_max = (tens_q == MAX_T) && (ones_q == MAX_O);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (inc) begin
      if (at_max) begin
        tens_d = 4'd0;
        ones_d = 4'd0;
      end else if (ones_q == 4'd9) begin
        tens_d = tens_q + 4'd1;
        ones_d = 4'd0;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tens_q <= load_val[7:4];
      ones_q <= load_val[3:0];
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens  = tens_q;
  assign ones  = ones_q;
  assign carry = inc && at_max;

endmodule

// File: rtl/clock_time_core.sv
// Time-of-day engine: 1 Hz prescaler, BCD h/m/s counters and a button-driven
// set mode, mapped onto the 8-digit display driver inputs.
module clock_time_core
  import clock_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int INIT_HOUR = 0,
  parameter int INIT_MIN  = 0,
  parameter int INIT_SEC  = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  output logic [3:0] led8Number,
  output logic [3:0] led7Number,
  output logic [3:0] led6Number,
  output logic [3:0] led5Number,
  output logic [3:0] led4Number,
  output logic [3:0] led3Number,
  output logic [3:0] led2Number,
  output logic [3:0] led1Number,
  output logic [7:0] point,
  output logic       is_shine,
  output logic [7:0] which_shine,
  output logic       tick_1hz
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

  localparam logic [7:0] INIT_H_BCD = to_bcd(INIT_HOUR);
  localparam logic [7:0] INIT_M_BCD = to_bcd(INIT_MIN);
  localparam logic [7:0] INIT_S_BCD = to_bcd(INIT_SEC);

  state_e           state_q, state_d;
  logic             is_shine_q, is_shine_d;
  logic [7:0]       which_shine_q, which_shine_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic tick, inc_hit;
  logic sec_inc, min_inc, hr_inc;
  logic sec_carry, min_carry, day_wrap_unused;
  logic [3:0] h_t, h_o, m_t, m_o, s_t, s_o;

  // Mode beats next beats inc; inc only survives when neither other button fires.
  assign inc_hit = btn_inc && !btn_mode && !btn_next;
  assign tick    = (state_q == RUN) && (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (state_q == RUN) begin
      if (btn_mode) state_d = SET_HOUR;
      else          cnt_d   = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end else if (btn_mode) begin
      state_d = RUN;
    end else if (btn_next) begin
      case (state_q)
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default:  state_d = SET_HOUR;
      endcase
    end

    is_shine_d = (state_d != RUN);
    case (state_d)
      SET_HOUR: which_shine_d = MASK_HOUR;
      SET_MIN:  which_shine_d = MASK_MIN;
      SET_SEC:  which_shine_d = MASK_SEC;
      default:  which_shine_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      is_shine_q    <= 1'b0;
      which_shine_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      is_shine_q    <= is_shine_d;
      which_shine_q <= which_shine_d;
    end
  end

  // Carries ripple only from the tick; set-mode edits never spill into the next field.
  assign sec_inc = tick || (inc_hit && state_q == SET_SEC);
  assign min_inc = (tick && sec_carry) || (inc_hit && state_q == SET_MIN);
  assign hr_inc  = (tick && sec_carry && min_carry) || (inc_hit && state_q == SET_HOUR);

  bcd_mod_counter #(.MOD(60)) u_sec (
    .clk(clk), .reset_n(reset_n), .load_val(INIT_S_BCD), .inc(sec_inc),
    .tens(s_t), .ones(s_o), .carry(sec_carry)
  );

  bcd_mod_counter #(.MOD(60)) u_min (
    .clk(clk), .reset_n(reset_n), .load_val(INIT_M_BCD), .inc(min_inc),
    .tens(m_t), .ones(m_o), .carry(min_carry)
  );

  bcd_mod_counter #(.MOD(24)) u_hour (
    .clk(clk), .reset_n(reset_n), .load_val(INIT_H_BCD), .inc(hr_inc),
    .tens(h_t), .ones(h_o), .carry(day_wrap_unused)
  );

  assign led8Number  = h_t;
  assign led7Number  = h_o;
  assign led6Number  = DIG_DASH;
  assign led5Number  = m_t;
  assign led4Number  = m_o;
  assign led3Number  = DIG_DASH;
  assign led2Number  = s_t;
  assign led1Number  = s_o;
  assign point       = 8'hFF;
  assign is_shine    = is_shine_q;
  assign which_shine = which_shine_q;
  assign tick_1hz    = tick;

endmodule

// File: tb/tb_clock_time_core.sv
// Randomized bench for clock_time_core: a seconds-of-day reference model checked
// every cycle, plus literal expectations at the scripted milestones.
module tb_clock_time_core;

  localparam int CLK_HZ = 10;
  localparam int IH = 23, IM = 59, IS = 58;
  localparam int INIT_SECS = IH * 3600 + IM * 60 + IS;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_mode = 1'b0, btn_next = 1'b0, btn_inc = 1'b0;
  logic [3:0] led8Number, led7Number, led6Number, led5Number;
  logic [3:0] led4Number, led3Number, led2Number, led1Number;
  logic [7:0] point, which_shine;
  logic is_shine, tick_1hz;

  int checks = 0;
  int failures = 0;
  int tick_seen = 0;
  bit chk_en = 1'b0;

  // Reference state: time as seconds of day, state 0=run 1=hour 2=min 3=sec.
  int m_secs = INIT_SECS;
  int m_st = 0;
  int m_pre = 0;

  clock_time_core #(.CLK_HZ(CLK_HZ), .INIT_HOUR(IH), .INIT_MIN(IM), .INIT_SEC(IS)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .led8Number(led8Number), .led7Number(led7Number), .led6Number(led6Number),
    .led5Number(led5Number), .led4Number(led4Number), .led3Number(led3Number),
    .led2Number(led2Number), .led1Number(led1Number),
    .point(point), .is_shine(is_shine), .which_shine(which_shine), .tick_1hz(tick_1hz)
  );

  always #5 clk = ~clk;

  function automatic void model_step(input int secs, input int st, input int pre,
                                     input logic rn, input logic bm, input logic bn, input logic bi,
                                     output int nsecs, output int nst, output int npre);
    int h, m, s;
    nsecs = secs; nst = st; npre = pre;
    if (!rn) begin
      nsecs = INIT_SECS; nst = 0; npre = 0;
      return;
    end
    if (st == 0 && pre == CLK_HZ - 1) nsecs = (secs + 1) % 86400;
    if (bm) begin
      nst = (st == 0) ? 1 : 0;
      npre = 0;
    end else if (st == 0) begin
      npre = (pre + 1) % CLK_HZ;
    end else begin
      npre = 0;
      if (bn) begin
        nst = (st % 3) + 1;
      end else if (bi) begin
        h = secs / 3600; m = (secs / 60) % 60; s = secs % 60;
        if (st == 1) h = (h + 1) % 24;
        else if (st == 2) m = (m + 1) % 60;
        else s = (s + 1) % 60;
        nsecs = h * 3600 + m * 60 + s;
      end
    end
  endfunction

  function automatic logic [31:0] digits_of(input int secs);
    int h, m, s;
    h = secs / 3600; m = (secs / 60) % 60; s = secs % 60;
    return {4'(h / 10), 4'(h % 10), 4'hA, 4'(m / 10), 4'(m % 10), 4'hA, 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [49:0] expect_vec();
    logic [7:0] mask;
    case (m_st)
      1: mask = 8'hC0;
      2: mask = 8'h18;
      3: mask = 8'h03;
      default: mask = 8'h00;
    endcase
    return {digits_of(m_secs), 8'hFF, (m_st != 0), mask, (m_st == 0 && m_pre == CLK_HZ - 1)};
  endfunction

  function automatic logic [31:0] dut_digits();
    return {led8Number, led7Number, led6Number, led5Number,
            led4Number, led3Number, led2Number, led1Number};
  endfunction

  // Reference model advances on every active edge from the sampled inputs.
  initial begin
    int ns, nst, np;
    forever begin
      @(posedge clk);
      model_step(m_secs, m_st, m_pre, reset_n, btn_mode, btn_next, btn_inc, ns, nst, np);
      m_secs = ns; m_st = nst; m_pre = np;
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    logic [49:0] act, exp_v;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        act   = {dut_digits(), point, is_shine, which_shine, tick_1hz};
        exp_v = expect_vec();
        checks++;
        if (act !== exp_v) begin
          failures++;
          $display("FAIL cycle_model t=%0t got=%h want=%h", $time, act, exp_v);
        end
        if (tick_1hz) tick_seen++;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic cyc(input logic m, input logic n, input logic i);
    @(negedge clk);
    #1;
    reset_n = 1'b1; btn_mode = m; btn_next = n; btn_inc = i;
  endtask

  task automatic rst_cyc();
    @(negedge clk);
    #1;
    reset_n = 1'b0; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
  endtask

  initial begin
    int t0, n, r;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    #1;
    check("reset_digits", dut_digits(), 32'h23A59A58);
    check("reset_shine", {is_shine, which_shine}, 9'h000);
    check("reset_point", point, 8'hFF);
    check("reset_tick", tick_1hz, 1'b0);

    tick_seen = 0;
    reset_n = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      cyc(0, 0, 0);
      if (k == 10) check("tick1_digits", dut_digits(), 32'h23A59A59);
      if (k == 20) check("rollover_digits", dut_digits(), 32'h00A00A00);
    end
    check("run35_digits", dut_digits(), 32'h00A00A01);
    check("run35_ticks", tick_seen, 3);

    t0 = tick_seen;
    cyc(1, 0, 0);
    repeat (25) cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("set_hour_digits", dut_digits(), 32'h01A00A01);
    check("set_hour_shine", {is_shine, which_shine}, 9'h1C0);
    check("set_no_ticks", tick_seen, t0);

    cyc(0, 1, 0); cyc(0, 0, 0);
    check("next_min_mask", which_shine, 8'h18);
    cyc(0, 1, 0); cyc(0, 0, 0);
    check("next_sec_mask", which_shine, 8'h03);
    cyc(0, 1, 0); cyc(0, 0, 0);
    check("next_hour_mask", which_shine, 8'hC0);

    cyc(0, 1, 0);
    repeat (59) cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("min59_digits", dut_digits(), 32'h01A59A01);
    cyc(0, 0, 1); cyc(0, 0, 0);
    check("min_wrap_digits", dut_digits(), 32'h01A00A01);

    cyc(1, 1, 1); cyc(0, 0, 0);
    check("prio_exit_shine", {is_shine, which_shine}, 9'h000);
    check("prio_no_inc", dut_digits(), 32'h01A00A01);
    n = 1;
    while (!tick_1hz && n < 40) begin
      cyc(0, 0, 0);
      n++;
    end
    check("first_tick_latency", n, 10);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 999) == 0) rst_cyc();
      else cyc($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 25);
    end

    rst_cyc();
    cyc(0, 0, 0);
    cyc(1, 0, 0); cyc(0, 1, 0); cyc(0, 1, 0);
    repeat (4) cyc(0, 0, 1);
    cyc(0, 0, 0);
    check("set_sec_mask", which_shine, 8'h03);
    check("set_sec_digits", dut_digits(), 32'h23A59A02);
    rst_cyc();
    cyc(0, 0, 0);
    check("midset_reset_digits", dut_digits(), 32'h23A59A58);
    check("midset_reset_shine", {is_shine, which_shine}, 9'h000);
    check("midset_reset_point", point, 8'hFF);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_time_core.md
# clock_time_core

Time-of-day engine for the digital clock: keeps hours/minutes/seconds in BCD, runs a 1 Hz prescaler, and handles a button-driven set mode. It sits directly upstream of the 8-digit scanning display driver. Every output maps 1:1 onto that driver's digit, decimal-point and blink inputs.

## Interface
- CLK_HZ, 100_000_000, clk cycles per second; sims use a small value (e.g. 10)
- INIT_HOUR, 0, hour loaded at reset (0..23)
- INIT_MIN, 0, minute loaded at reset (0..59)
- INIT_SEC, 0, second loaded at reset (0..59)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- btn_mode  in  1  single-cycle pulse, already debounced; enter/leave set mode
- btn_next  in  1  single-cycle pulse; select next field in set mode
- btn_inc  in  1  single-cycle pulse; increment the selected field
- led8Number..led1Number  out  4 each  digit codes; led8 is the leftmost digit
- point  out  8  decimal points, active-low; constant 8'hFF (all off)
- is_shine  out  1  1 while in any set state
- which_shine  out  8  blink mask per digit, bit i = led(i+1)
- tick_1hz  out  1  one-cycle pulse at each second boundary in RUN; for debug and the alarm stage

## Operation
- Display layout, led8..led1: H-tens, H-ones, 4'hA (dash), M-tens, M-ones, 4'hA, S-tens, S-ones.
- Digit codes are 0..9. 4'hA is the dash code and 4'hB is the blank code in the display decoder.
- States: RUN, SET_HOUR, SET_MIN, SET_SEC. Reset state is RUN.
- State transitions:
  - RUN + btn_mode -> SET_HOUR.
  - Any SET state + btn_mode -> RUN.
  - btn_next cycles SET_HOUR -> SET_MIN -> SET_SEC -> SET_HOUR. btn_next is ignored in RUN.
- Blink masks: SET_HOUR -> which_shine = 8'b1100_0000; SET_MIN -> 8'b0001_1000; SET_SEC -> 8'b0000_0011; RUN -> 8'h00 with is_shine = 0.
- RUN counting:
  - The prescaler counts 0..CLK_HZ-1 and wraps.
  - At count CLK_HZ-1, tick_1hz = 1 for that cycle and seconds increment.
  - Seconds 59 -> 00 with a carry to minutes. Minutes 59 -> 00 with a carry to hours. Hours 23 -> 00.
  - 23:59:59 + tick -> 00:00:00.
- SET states:
  - Time is frozen, the prescaler is held at 0, and tick_1hz = 0.
  - btn_inc adds 1 to the selected field only: hours wrap 23 -> 00; minutes and seconds wrap 59 -> 00.
  - btn_inc never produces a carry into another field.
  - btn_inc is ignored in RUN.
- Leaving a SET state (-> RUN): the prescaler restarts from 0. The first tick comes CLK_HZ cycles after the transition cycle.
- Simultaneous pulses: btn_mode has priority over btn_next, which has priority over btn_inc. Lower-priority pulses in the same cycle are dropped.
- Tick and btn_mode in the same RUN cycle: the increment is committed and the state moves to SET_HOUR, both at the same edge.
- All arithmetic is BCD per digit. Every tens/ones pair stays valid: tens ≤ 5 (≤ 2 for hours), ones ≤ 9, hours ≤ 23.

## Timing
- Reset values: time = INIT_HOUR:INIT_MIN:INIT_SEC in BCD, state RUN, prescaler 0, tick_1hz 0, is_shine 0, which_shine 8'h00, point 8'hFF.
- At reset with defaults, digits led8..led1 = 0,0,A,0,0,A,0,0.
- reset_n low mid-operation, including in a SET state: all of the above are restored at the next clk edge.
- Time registers update on the edge following a tick or btn_inc. Digit outputs are driven directly from those registers (0 additional latency).
- is_shine/which_shine come straight from the state register. They change on the edge that samples the button pulse.
- Button pulses are sampled each cycle with no internal edge detection. A pulse held for N cycles acts as N presses.
- With CLK_HZ = 10, tick_1hz asserts on cycles 10, 20, 30, … after reset release.

## Structure
- Package clock_pkg holds:
  - state enum {RUN, SET_HOUR, SET_MIN, SET_SEC}
  - DIG_DASH = 4'hA, DIG_BLANK = 4'hB
  - the three blink-mask constants
- Sub-module bcd_mod_counter, instantiated three times (modulus 60, 60, 24). Its ports:
  - inputs: clk, reset_n, load value, inc
  - outputs: tens, ones, carry (carry = inc && at max)
- Top level contains the prescaler, the FSM, the increment steering and the digit mapping.

## Test plan
- Reset and run: CLK_HZ = 10, reset then 35 cycles -> 00:00:03 displayed, tick_1hz seen 3 times.
- Rollover: INIT = 23:59:58, two ticks -> 23:59:59 then 00:00:00, with every digit correct on each edge.
- Set hours: btn_mode, then btn_inc ×25 from hour 00.
  - -> hour 01, minutes/seconds unchanged.
  - -> is_shine = 1, which_shine = 8'hC0.
  - -> no ticks while in set mode.
- Field cycling: btn_mode, btn_next ×3 -> which_shine goes C0, 18, 03, C0. btn_inc at minutes 59 -> 00 with hour unchanged.
- Priority and exit: btn_mode + btn_next + btn_inc in the same cycle while in SET_MIN -> RUN, no increment, is_shine 0, first tick exactly CLK_HZ cycles later.
- Reset mid-set: in SET_SEC after edits, pulse reset_n low for 1 cycle -> INIT time, RUN, which_shine 00, point FF.
